// File: rtl/dp_sync_ram_pkg.sv
// Shared definitions for dp_sync_ram: FSM state encoding, byte-lane width, index sizing.
package dp_sync_ram_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dp_sync_ram_byte_parity_gen.sv
// Combinational even-parity generator, one bit per byte lane.
// Only compiled when DP_SYNC_RAM_PARITY_EN is defined (its sole user).
`ifdef DP_SYNC_RAM_PARITY_EN
module byte_parity_gen
  import dp_sync_ram_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [DATA_W-1:0]        i_data,
  output logic [DATA_W/BYTE_W-1:0] o_parity
);

  always_comb begin
    o_parity = '0;
    for (int unsigned i = 0; i < DATA_W / BYTE_W; i++) begin
      o_parity[i] = ^i_data[i*BYTE_W +: BYTE_W];
    end
  end

endmodule
`endif

// File: rtl/dp_sync_ram.sv
// Synchronous 1W/1R RAM: byte-enable writes, registered reads, write-first forwarding,
// post-reset clear sequence. Optional per-byte parity under DP_SYNC_RAM_PARITY_EN.
module dp_sync_ram
  import dp_sync_ram_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic [ADDR_W-1:0]        write_adr,
  input  logic [DATA_W-1:0]        data_in,
  input  logic [DATA_W/BYTE_W-1:0] byte_en,
  input  logic                     rd,
  input  logic [ADDR_W-1:0]        read_adr,
  output logic [DATA_W-1:0]        data_out,
  output logic                     rd_valid,
  output logic                     ready,
  output logic                     rd_err
);

  localparam int unsigned     NB       = DATA_W / BYTE_W;
  localparam int unsigned     IDX_W    = idx_width(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  state_t            r_state;
  logic [IDX_W-1:0]  r_clr_cnt;
  logic [DATA_W-1:0] r_data_out;
  logic              r_rd_valid;
  logic              r_ready;
  logic              r_rd_err;

  logic              w_wr_in, w_rd_in, w_wr_en, w_collide, w_par_err;
  logic [IDX_W-1:0]  w_wr_idx, w_rd_idx;
  logic [DATA_W-1:0] w_rd_word, w_merged;

  assign w_wr_in   = {1'b0, write_adr} < DEPTH_L;
  assign w_rd_in   = {1'b0, read_adr}  < DEPTH_L;
  assign w_wr_idx  = write_adr[IDX_W-1:0];
  assign w_rd_idx  = read_adr[IDX_W-1:0];
  assign w_wr_en   = (r_state == ST_READY) && wr && w_wr_in && (|byte_en);
  assign w_collide = w_wr_en && rd && w_rd_in && (write_adr == read_adr);
  assign w_rd_word = r_mem[w_rd_idx];

  // Write-first: on a same-address collision the read sees the post-write word.
  always_comb begin
    w_merged = w_rd_word;
    for (int unsigned i = 0; i < NB; i++) begin
      if (byte_en[i]) w_merged[i*BYTE_W +: BYTE_W] = data_in[i*BYTE_W +: BYTE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_wr_en) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (byte_en[i]) r_mem[w_wr_idx][i*BYTE_W +: BYTE_W] <= data_in[i*BYTE_W +: BYTE_W];
      end
    end
  end

`ifdef DP_SYNC_RAM_PARITY_EN
  logic [NB-1:0] r_par [DEPTH];
  logic [NB-1:0] w_wr_par, w_rd_calc;

  byte_parity_gen #(.DATA_W(DATA_W)) u_wr_par (.i_data(data_in),   .o_parity(w_wr_par));
  byte_parity_gen #(.DATA_W(DATA_W)) u_rd_par (.i_data(w_rd_word), .o_parity(w_rd_calc));

  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_par[r_clr_cnt] <= '0;
    end else if (w_wr_en) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (byte_en[i]) r_par[w_wr_idx][i] <= w_wr_par[i];
      end
    end
  end

  assign w_par_err = |(w_rd_calc ^ r_par[w_rd_idx]);
`else
  assign w_par_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_CLEAR;
      r_clr_cnt  <= '0;
      r_data_out <= '0;
      r_rd_valid <= 1'b0;
      r_ready    <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_rd_valid <= 1'b0;
          r_rd_err   <= 1'b0;
          if (r_clr_cnt == LAST_IDX) begin
            r_state <= ST_READY;
            r_ready <= 1'b1;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        ST_READY: begin
          if (rd) begin
            r_rd_valid <= 1'b1;
            if (!w_rd_in) begin
              r_data_out <= '0;
              r_rd_err   <= 1'b0;
            end else if (w_collide) begin
              r_data_out <= w_merged;
              r_rd_err   <= 1'b0;
            end else begin
              r_data_out <= w_rd_word;
              r_rd_err   <= w_par_err;
            end
          end else begin
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
          end
        end
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

  assign data_out = r_data_out;
  assign rd_valid = r_rd_valid;
  assign ready    = r_ready;
  assign rd_err   = r_rd_err;

endmodule

// File: tb/tb_dp_sync_ram.sv
// Self-checking bench for dp_sync_ram: behavioural array model, per-cycle compare, directed + random stimulus.
module tb_dp_sync_ram;

  localparam int DW    = 64;
  localparam int AW    = 10;
  localparam int DEPTH = 512;
  localparam int NB    = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic [AW-1:0] write_adr = '0;
  logic [AW-1:0] read_adr = '0;
  logic [DW-1:0] data_in = '0;
  logic [NB-1:0] byte_en = '0;
  logic [DW-1:0] data_out;
  logic          rd_valid, ready, rd_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dp_sync_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .write_adr(write_adr), .data_in(data_in),
    .byte_en(byte_en), .rd(rd), .read_adr(read_adr), .data_out(data_out),
    .rd_valid(rd_valid), .ready(ready), .rd_err(rd_err)
  );

  // Behavioural model: plain array, cycle counter for the clear phase.
  logic [DW-1:0] m_mem [1 << AW];
  logic [NB-1:0] m_bad [1 << AW];
  int            m_cnt;
  logic          m_ready, m_valid, m_err;
  logic [DW-1:0] m_data;
  bit            chk_en = 0;

  always @(posedge clk or negedge rst_n) begin
    logic [DW-1:0] word;
    logic [NB-1:0] bad;
    if (!rst_n) begin
      m_cnt = 0; m_ready = 0; m_valid = 0; m_err = 0; m_data = '0;
      for (int i = 0; i < (1 << AW); i++) begin m_mem[i] = '0; m_bad[i] = '0; end
    end else if (!m_ready) begin
      m_cnt++;
      m_valid = 0; m_err = 0;
      if (m_cnt == DEPTH) m_ready = 1;
    end else begin
      if (rd) begin
        m_valid = 1;
        if (int'(read_adr) < DEPTH) begin
          word = m_mem[read_adr];
          bad  = m_bad[read_adr];
          if (wr && write_adr == read_adr && byte_en != '0) begin
            for (int b = 0; b < NB; b++) if (byte_en[b]) word[b*8 +: 8] = data_in[b*8 +: 8];
            bad = '0;
          end
          m_data = word;
          m_err  = |bad;
        end else begin
          m_data = '0; m_err = 0;
        end
      end else begin
        m_valid = 0; m_err = 0;
      end
      if (wr && int'(write_adr) < DEPTH) begin
        for (int b = 0; b < NB; b++) begin
          if (byte_en[b]) begin
            m_mem[write_adr][b*8 +: 8] = data_in[b*8 +: 8];
            m_bad[write_adr][b] = 1'b0;
          end
        end
      end
    end
  end

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check64(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check1 ("cyc_ready",    ready,    m_ready);
      check1 ("cyc_rd_valid", rd_valid, m_valid);
      check64("cyc_data_out", data_out, m_data);
      check1 ("cyc_rd_err",   rd_err,   m_err);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rnd_adr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6)      return 10'h180 + AW'($urandom_range(0, 15));
    else if (r < 8) return 10'h1A4;
    else            return AW'($urandom_range(DEPTH, (1 << AW) - 1));
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1;
    check1 ("rst_ready",    ready,    1'b0);
    check1 ("rst_rd_valid", rd_valid, 1'b0);
    check64("rst_data_out", data_out, '0);
    check1 ("rst_rd_err",   rd_err,   1'b0);

    // Clear phase: ready must rise on exactly the DEPTH-th edge after release.
    rst_n = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      cyc();
      check1("t1_ready_timing", ready, (i == DEPTH));
    end
    for (int a = 0; a < DEPTH; a++) begin
      rd = 1'b1; read_adr = AW'(a);
      cyc();
      check1 ("t1_valid", rd_valid, 1'b1);
      check64("t1_zero",  data_out, '0);
    end
    rd = 1'b0;
    cyc();

    // Full-word write then read.
    wr = 1'b1; write_adr = 10'h184; data_in = 64'h0123_4567_89AB_CDEF; byte_en = 8'hFF;
    cyc();
    wr = 1'b0; rd = 1'b1; read_adr = 10'h184;
    cyc();
    check1 ("t2_valid", rd_valid, 1'b1);
    check64("t2_data",  data_out, 64'h0123_4567_89AB_CDEF);
    rd = 1'b0;
    cyc();
    check1 ("t2_hold_valid", rd_valid, 1'b0);
    check64("t2_hold_data",  data_out, 64'h0123_4567_89AB_CDEF);

    // Partial byte-enable write.
    wr = 1'b1; data_in = '1; byte_en = 8'h0F;
    cyc();
    wr = 1'b0; rd = 1'b1;
    cyc();
    check64("t3_data", data_out, 64'h0123_4567_FFFF_FFFF);

    // Same-address collision, write-first.
    wr = 1'b1; rd = 1'b1; write_adr = 10'h1A4; read_adr = 10'h1A4;
    data_in = 64'hAAAA_AAAA_AAAA_AAAA; byte_en = 8'hF0;
    cyc();
    check64("t4_collide", data_out, 64'hAAAA_AAAA_0000_0000);
    check1 ("t4_err",     rd_err,   1'b0);
    wr = 1'b0;
    cyc();
    check64("t4_stored", data_out, 64'hAAAA_AAAA_0000_0000);

    // Out-of-range: write dropped, read returns 0 valid.
    wr = 1'b1; write_adr = 10'h3FF; data_in = 64'hDEAD_BEEF_DEAD_BEEF; byte_en = 8'hFF;
    rd = 1'b0;
    cyc();
    wr = 1'b0; rd = 1'b1; read_adr = 10'h3FF;
    cyc();
    check1 ("oor_valid", rd_valid, 1'b1);
    check64("oor_data",  data_out, '0);
    check1 ("oor_err",   rd_err,   1'b0);
    rd = 1'b0;
    cyc();

`ifdef DP_SYNC_RAM_PARITY_EN
    dut.r_par[9'h184][0] = ~dut.r_par[9'h184][0];
    m_bad[10'h184][0] = ~m_bad[10'h184][0];
    rd = 1'b1; read_adr = 10'h184;
    cyc();
    check1("t6_err_bad",   rd_err,   1'b1);
    check1("t6_err_valid", rd_valid, 1'b1);
    read_adr = 10'h1A4;
    cyc();
    check1("t6_err_clean", rd_err, 1'b0);
    rd = 1'b0;
    cyc();
`endif

    // Random traffic in a narrow window for frequent collisions plus out-of-range hits.
    for (int i = 0; i < 3000; i++) begin
      wr = ($urandom_range(0, 1) == 1);
      rd = ($urandom_range(0, 3) != 0);
      write_adr = rnd_adr();
      read_adr  = ($urandom_range(0, 3) == 0) ? write_adr : rnd_adr();
      data_in   = {$urandom, $urandom};
      byte_en   = NB'($urandom);
      cyc();
    end

    // Reset in the middle of a write burst, with traffic continuing during clear.
    for (int i = 0; i < 8; i++) begin
      wr = 1'b1; rd = 1'b0; write_adr = 10'h180 + AW'(i);
      data_in = {$urandom, $urandom} | 64'h1; byte_en = 8'hFF;
      if (i == 5) rst_n = 1'b0;
      cyc();
    end
    cyc();
    rst_n = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      wr = ($urandom_range(0, 1) == 1); rd = ($urandom_range(0, 1) == 1);
      write_adr = rnd_adr(); read_adr = rnd_adr();
      data_in = {$urandom, $urandom}; byte_en = '1;
      cyc();
      check1("t5_ready_timing", ready, (i == DEPTH));
    end
    wr = 1'b0;
    for (int a = 'h180; a < 'h190; a++) begin
      rd = 1'b1; read_adr = AW'(a);
      cyc();
      check64("t5_recleared", data_out, '0);
    end
    rd = 1'b1; read_adr = 10'h1A4;
    cyc();
    check64("t5_recleared_1a4", data_out, '0);
    rd = 1'b0;
    cyc();
    cyc();

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
